// File: rtl/fetch_queue.sv
// Instruction-bundle fetch queue: issues 16-byte bundle fetches, buffers in-order responses, squashes on redirect.
// Optional empty-queue bypass of responses to the outputs is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic         mem_req,
   output logic [31:0]  mem_addr,
   input  logic         mem_ready,
   input  logic         mem_rsp_valid,
   input  logic [127:0] mem_rsp_bundle,
   input  logic         stall,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output logic         out_valid,
   output logic [31:0]  out_pc,
   output logic [31:0]  ixu1_inst,
   output logic [31:0]  ixu2_inst,
   output logic [31:0]  lsu_inst,
   output logic [31:0]  branch_inst
);

   localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW         = AW + 1;
   // Stale responses can pile up across back-to-back redirects, so discard gets headroom.
   localparam int          DW         = 8;
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_A = {RESET_PC[31:4], 4'b0000};
   localparam logic [CW:0] DEPTH_W    = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [DW-1:0] DIS_ONE  = DW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [127:0]  r_bundle [DEPTH];
   logic [31:0]   r_pcq    [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outst;
   logic [DW-1:0] r_discard;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_rsp_pc;
   logic [31:0]   r_last_pc;
   logic          r_req_en;

   logic [CW:0]   w_occ;
   logic          w_req;
   logic          w_acc;
   logic          w_rsp_live;
   logic          w_q_valid;
   logic          w_bypass;
   logic          w_out_valid;
   logic          w_pop;
   logic          w_push;
   logic [127:0]  w_head_bundle;
   logic [31:0]   w_head_pc;
   logic [31:0]   w_redirect_pc_a;
   logic [DW-1:0] w_inflight;
   logic          w_unused;

   assign w_unused        = ^redirect_pc[3:0];
   assign w_redirect_pc_a = {redirect_pc[31:4], 4'b0000};
   assign w_occ           = {1'b0, r_count} + {1'b0, r_outst};
   assign w_req           = r_req_en && (w_occ < DEPTH_W) && !redirect;
   assign w_acc           = w_req && mem_ready;
   assign w_rsp_live      = mem_rsp_valid && (r_discard == '0);
   assign w_q_valid       = (r_count != '0);
   assign w_inflight      = r_discard + DW'(r_outst);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass = !w_q_valid && w_rsp_live && !redirect;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_out_valid   = w_q_valid || w_bypass;
   assign w_head_bundle = w_q_valid ? r_bundle[r_rd_ptr] : mem_rsp_bundle;
   // Responses come back in order, so the next live response always belongs to r_rsp_pc.
   assign w_head_pc     = w_q_valid ? r_pcq[r_rd_ptr] : r_rsp_pc;
   assign w_pop         = w_q_valid && !stall && !redirect;
   assign w_push        = w_rsp_live && !redirect && !(w_bypass && !stall);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_outst    <= '0;
         r_discard  <= '0;
         r_fetch_pc <= RESET_PC_A;
         r_rsp_pc   <= RESET_PC_A;
         r_last_pc  <= RESET_PC;
         r_req_en   <= 1'b0;
      end else begin
         r_req_en <= 1'b1;
         if (w_out_valid) r_last_pc <= w_head_pc;
         if (redirect) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_discard  <= (mem_rsp_valid && (w_inflight != '0)) ? w_inflight - DIS_ONE : w_inflight;
            r_fetch_pc <= w_redirect_pc_a;
            r_rsp_pc   <= w_redirect_pc_a;
         end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
            if (w_acc && !w_rsp_live)      r_outst <= r_outst + CNT_ONE;
            else if (!w_acc && w_rsp_live) r_outst <= r_outst - CNT_ONE;
            if (mem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - DIS_ONE;
            if (w_acc)      r_fetch_pc <= r_fetch_pc + 32'd16;
            if (w_rsp_live) r_rsp_pc   <= r_rsp_pc + 32'd16;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_bundle[r_wr_ptr] <= mem_rsp_bundle;
         r_pcq[r_wr_ptr]    <= r_rsp_pc;
      end
   end

   assign mem_req     = w_req;
   assign mem_addr    = r_fetch_pc;
   assign out_valid   = w_out_valid;
   assign out_pc      = w_out_valid ? w_head_pc : r_last_pc;
   assign ixu1_inst   = w_out_valid ? w_head_bundle[31:0]   : NOP;
   assign ixu2_inst   = w_out_valid ? w_head_bundle[63:32]  : NOP;
   assign lsu_inst    = w_out_valid ? w_head_bundle[95:64]  : NOP;
   assign branch_inst = w_out_valid ? w_head_bundle[127:96] : NOP;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model with 1-cycle response latency and a
// scoreboard of expected head bundles; directed scenarios for reset, stall-fill, redirect and wrap.
module tb_fetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic         clk, rst;
   logic         mem_req, mem_ready, mem_rsp_valid;
   logic [31:0]  mem_addr;
   logic [127:0] mem_rsp_bundle;
   logic         stall, redirect;
   logic [31:0]  redirect_pc;
   logic         out_valid;
   logic [31:0]  out_pc, ixu1_inst, ixu2_inst, lsu_inst, branch_inst;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_bundle(mem_rsp_bundle),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_pc(out_pc),
      .ixu1_inst(ixu1_inst), .ixu2_inst(ixu2_inst), .lsu_inst(lsu_inst), .branch_inst(branch_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [127:0] b; } ent_t;
   typedef struct { logic [31:0] a; bit stale; } req_t;

   ent_t        exp_q[$];
   req_t        pend[$];
   logic [31:0] pop_log[$];
   logic [31:0] m_pc, m_last;
   int          n_vec, n_bad, n_acc;
   logic        s_ov, s_req;
   logic [31:0] s_addr, s_pc;

   function automatic logic [127:0] bfun(input logic [31:0] a);
      return {32'h0000_0063 + a, 32'h0000_2003 + a, 32'h0010_0093 + a, 32'h0020_0113 + a};
   endfunction

   task automatic run_cycle(input bit redir, input logic [31:0] rpc, input bit stl,
                            input bit rdy, input bit rsp_en);
      req_t r;
      bit   resp, ev, er;
      int   outst;
      ent_t e;
      @(negedge clk);
      redirect = redir; redirect_pc = rpc; stall = stl; mem_ready = rdy;
      outst = 0;
      foreach (pend[i]) if (!pend[i].stale) outst++;
      resp = rsp_en && (pend.size() > 0);
      r.a = 32'h0; r.stale = 1'b1;
      if (resp) begin
         r = pend.pop_front();
         mem_rsp_valid = 1'b1; mem_rsp_bundle = bfun(r.a);
      end else begin
         mem_rsp_valid = 1'b0; mem_rsp_bundle = '0;
      end
      #1;
      s_ov = out_valid; s_req = mem_req; s_addr = mem_addr; s_pc = out_pc;
      ev = (exp_q.size() > 0);
      er = ((exp_q.size() + outst) < DEPTH) && !redir;
      n_vec++;
      if (out_valid !== ev) begin
         n_bad++; $display("FAIL out_valid: got %b exp %b t=%0t", out_valid, ev, $time);
      end
      n_vec++;
      if (mem_req !== er) begin
         n_bad++; $display("FAIL mem_req: got %b exp %b t=%0t", mem_req, er, $time);
      end
      if (er) begin
         n_vec++;
         if (mem_addr !== m_pc) begin
            n_bad++; $display("FAIL mem_addr: got %h exp %h t=%0t", mem_addr, m_pc, $time);
         end
      end
      if (ev) begin
         e = exp_q[0];
         n_vec++;
         if (out_pc !== e.pc) begin
            n_bad++; $display("FAIL head_pc: got %h exp %h t=%0t", out_pc, e.pc, $time);
         end
         n_vec++;
         if ({branch_inst, lsu_inst, ixu2_inst, ixu1_inst} !== e.b) begin
            n_bad++; $display("FAIL head_slots: got %h exp %h t=%0t",
                              {branch_inst, lsu_inst, ixu2_inst, ixu1_inst}, e.b, $time);
         end
         m_last = e.pc;
      end else begin
         n_vec++;
         if (out_pc !== m_last) begin
            n_bad++; $display("FAIL idle_pc: got %h exp %h t=%0t", out_pc, m_last, $time);
         end
         n_vec++;
         if ({branch_inst, lsu_inst, ixu2_inst, ixu1_inst} !== {4{NOP}}) begin
            n_bad++; $display("FAIL idle_nop: got %h exp %h t=%0t",
                              {branch_inst, lsu_inst, ixu2_inst, ixu1_inst}, {4{NOP}}, $time);
         end
      end
      if (redir) begin
         exp_q.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_pc = {rpc[31:4], 4'b0000};
      end else begin
         if (ev && !stl) begin
            pop_log.push_back(exp_q[0].pc);
            void'(exp_q.pop_front());
         end
         if (resp && !r.stale) exp_q.push_back('{r.a, bfun(r.a)});
         if (er && rdy) begin
            pend.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd16;
            n_acc++;
         end
      end
   endtask

   task automatic do_assert();
      rst = 1'b0;
      redirect = 1'b0; redirect_pc = '0; stall = 1'b0; mem_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_bundle = '0;
      exp_q.delete(); pend.delete(); pop_log.delete();
      m_pc = RPC; m_last = RPC; n_acc = 0;
   endtask

   task automatic do_release();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (mem_req !== 1'b0) begin
         n_bad++; $display("FAIL req_at_release: got %b exp 0", mem_req);
      end
   endtask

   task automatic test_reset();
      do_assert();
      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++; $display("FAIL reset_ctl: got ov=%b req=%b exp 0 0", out_valid, mem_req);
      end
      n_vec++;
      if (out_pc !== RPC) begin
         n_bad++; $display("FAIL reset_pc: got %h exp %h", out_pc, RPC);
      end
      n_vec++;
      if ({ixu1_inst, ixu2_inst, lsu_inst, branch_inst} !== {4{NOP}}) begin
         n_bad++; $display("FAIL reset_nop: got %h %h %h %h exp %h", ixu1_inst, ixu2_inst, lsu_inst, branch_inst, NOP);
      end
      do_release();
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (s_req !== 1'b1 || s_addr !== RPC) begin
         n_bad++; $display("FAIL first_req: got req=%b addr=%h exp 1 %h", s_req, s_addr, RPC);
      end
   endtask

   task automatic test_stream();
      int first_valid;
      bit seen;
      do_assert(); do_release();
      first_valid = -1; seen = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
         if (s_ov && !seen) begin
            seen = 1'b1; first_valid = c;
            n_vec++;
            if (ixu1_inst !== 32'h0020_0113 || ixu2_inst !== 32'h0010_0093 ||
                lsu_inst !== 32'h0000_2003 || branch_inst !== 32'h0000_0063) begin
               n_bad++; $display("FAIL slot_map: got %h %h %h %h exp 00200113 00100093 00002003 00000063",
                                 ixu1_inst, ixu2_inst, lsu_inst, branch_inst);
            end
         end
      end
      n_vec++;
      if (first_valid != 3) begin
         n_bad++; $display("FAIL rsp_latency: got cycle %0d exp 3", first_valid);
      end
      n_vec++;
      if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h10 || pop_log[2] !== 32'h20) begin
         n_bad++; $display("FAIL stream_order: got %0d pops exp >=3 starting 0,10,20", pop_log.size());
      end
   endtask

   task automatic test_stall_full();
      do_assert(); do_release();
      repeat (10) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      n_vec++;
      if (n_acc != DEPTH || s_req !== 1'b0) begin
         n_bad++; $display("FAIL full_stop: got acc=%0d req=%b exp %0d 0", n_acc, s_req, DEPTH);
      end
      pop_log.delete();
      repeat (8) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (pop_log.size() < 4 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h10 ||
          pop_log[2] !== 32'h20 || pop_log[3] !== 32'h30) begin
         n_bad++; $display("FAIL drain_order: got %0d pops exp 0,10,20,30", pop_log.size());
      end
   endtask

   task automatic test_redirect();
      do_assert(); do_release();
      repeat (3) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (s_ov !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
         n_bad++; $display("FAIL redirect_next: got ov=%b req=%b addr=%h exp 0 1 00000100", s_ov, s_req, s_addr);
      end
      pop_log.delete();
      repeat (10) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (pop_log.size() < 1 || pop_log[0] !== 32'h0000_0100) begin
         n_bad++; $display("FAIL redirect_first_pop: got %0d pops exp first 00000100", pop_log.size());
      end
   endtask

   task automatic test_redirect_rsp_stall();
      do_assert(); do_release();
      repeat (3) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      run_cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
      n_vec++;
      if (s_ov !== 1'b1) begin
         n_bad++; $display("FAIL pre_flush_valid: got %b exp 1", s_ov);
      end
      for (int c = 0; c < 3; c++) begin
         run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
         n_vec++;
         if (s_ov !== 1'b0) begin
            n_bad++; $display("FAIL discard_window: got ov=%b exp 0 at step %0d", s_ov, c);
         end
      end
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (s_ov !== 1'b1 || s_pc !== 32'h0000_0200) begin
         n_bad++; $display("FAIL post_discard: got ov=%b pc=%h exp 1 00000200", s_ov, s_pc);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      do_assert(); do_release();
      guard = 0;
      while (exp_q.size() != 2 && guard < 10) begin
         run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         guard++;
      end
      n_vec++;
      if (exp_q.size() != 2) begin
         n_bad++; $display("FAIL fill_two: got %0d queued exp 2 within 10 cycles", exp_q.size());
      end
      @(posedge clk);
      #2;
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_bad++; $display("FAIL queued_before_rst: got %b exp 1", out_valid);
      end
      do_assert();
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || mem_req !== 1'b0 || out_pc !== RPC ||
          {ixu1_inst, ixu2_inst, lsu_inst, branch_inst} !== {4{NOP}}) begin
         n_bad++; $display("FAIL mid_reset: got ov=%b req=%b pc=%h ixu1=%h exp 0 0 %h %h",
                           out_valid, mem_req, out_pc, ixu1_inst, RPC, NOP);
      end
      do_release();
      repeat (6) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_wrap();
      do_assert(); do_release();
      run_cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (s_addr !== 32'hFFFF_FFF0) begin
         n_bad++; $display("FAIL wrap_align: got %h exp fffffff0", s_addr);
      end
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (s_addr !== 32'h0000_0000) begin
         n_bad++; $display("FAIL wrap_addr: got %h exp 00000000", s_addr);
      end
      repeat (5) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      n_vec = 0; n_bad = 0;
      do_assert();
      test_reset();
      test_stream();
      test_stall_full();
      test_redirect();
      test_redirect_rsp_stall();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning bundle queue entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first bundle address after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  out  1  bundle fetch request valid.
REQ-006 SHALL have port mem_addr  out  32  byte address of requested bundle, 16-byte aligned.
REQ-007 SHALL have port mem_ready  in  1  memory accepts request this cycle.
REQ-008 SHALL have port mem_rsp_valid  in  1  response bundle valid; responses return in request order.
REQ-009 SHALL have port mem_rsp_bundle  in  128  response bundle.
REQ-010 SHALL have port stall  in  1  hazard stall; head bundle not consumed.
REQ-011 SHALL have port redirect  in  1  branch taken; squash and refetch.
REQ-012 SHALL have port redirect_pc  in  32  new fetch address.
REQ-013 SHALL have port out_valid  out  1  head bundle valid.
REQ-014 SHALL have port out_pc  out  32  address of head bundle.
REQ-015 SHALL have ports ixu1_inst, ixu2_inst, lsu_inst, branch_inst  out  32 each  head bundle slots.

Function
REQ-016 Slot mapping SHALL be ixu1=[31:0], ixu2=[63:32], lsu=[95:64], branch=[127:96].
REQ-017 When out_valid=0 all four slot outputs SHALL be 32'h0000_0013 (NOP); out_pc SHALL hold last value.
REQ-018 Request accepted when mem_req && mem_ready; fetch_pc SHALL then advance by 16, wrapping modulo 2^32.
REQ-019 mem_req SHALL be 1 only when occupancy + outstanding < DEPTH and redirect=0.
REQ-020 Outstanding counter SHALL increment on accepted request, decrement on mem_rsp_valid; simultaneous events net zero.
REQ-021 Each non-discarded response SHALL be written at the tail with its PC (queued alongside request order).
REQ-022 Head SHALL be consumed (popped) when out_valid && !stall.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; push when full SHALL not occur (guaranteed by REQ-019).
REQ-024 Without bypass (see Configuration) response-to-out_valid latency SHALL be exactly 1 cycle.
REQ-025 On redirect: queue SHALL be emptied and out_valid SHALL be 0 in the next cycle; fetch_pc SHALL load {redirect_pc[31:4],4'b0}.
REQ-026 On redirect: all currently outstanding responses SHALL be discarded via a discard counter loaded with outstanding count (minus any response arriving that same cycle).
REQ-027 While discard counter > 0 each mem_rsp_valid SHALL decrement it and SHALL not write the queue.
REQ-028 Redirect SHALL take priority over pop, push and request in the same cycle.
REQ-029 Redirect during stall SHALL still flush; stall SHALL not block redirect.
REQ-030 First request after redirect SHALL be issued the cycle after redirect, addressed to the redirect PC.

Reset
REQ-031 On rst=0: queue empty, outstanding=0, discard=0, fetch_pc=RESET_PC, out_pc=RESET_PC, mem_req=0, out_valid=0, slots=NOP.
REQ-032 mem_req SHALL first assert in the cycle after rst deasserts; reset mid-operation SHALL drop all queued and in-flight bundles.

Configuration
REQ-033 Macro FETCH_QUEUE_BYPASS_EN SHALL control empty-queue bypass.
REQ-034 With FETCH_QUEUE_BYPASS_EN defined: when queue empty, discard=0, redirect=0 and mem_rsp_valid=1, response SHALL appear on outputs combinationally same cycle with out_valid=1; if not consumed it SHALL be enqueued.
REQ-035 Without FETCH_QUEUE_BYPASS_EN: outputs SHALL come only from queue registers (REQ-024).

Verification
REQ-036 Reset then mem_ready=1, 1-cycle response latency, stall=0 -> mem_addr 0x0,0x10,0x20...; out_pc follows 1 cycle after each response (no bypass).
REQ-037 Response bundle 128'h00000063_00002003_00100093_00200113 -> ixu1=0x00200113, ixu2=0x00100093, lsu=0x00002003, branch=0x00000063.
REQ-038 DEPTH=4, stall=1 held -> exactly 4 requests accepted, then mem_req=0; release stall -> pops one per cycle, out_pc 0x0..0x30.
REQ-039 3 requests outstanding, redirect=1 with redirect_pc=0x104 -> next cycle out_valid=0, mem_addr=0x100; the 3 stale responses never reach outputs.
REQ-040 Redirect same cycle as mem_rsp_valid and stall=1 -> that response dropped, queue empty, discard count = outstanding-1.
REQ-041 rst asserted with 2 queued bundles -> immediately out_valid=0, slots=NOP, mem_req=0, out_pc=RESET_PC.
